ad_capture_ctrl: RTL and testbench
==================================

Name: ad_capture_ctrl

Overview:
- Capture sequencer for the ADS42 I/Q datapath. Sits after the async sample FIFO, in the sys_clk domain.
- Waits for ADC configuration to complete, optionally arms on an I-channel level trigger, then decimates and writes a programmed number of {Q,I} sample pairs into an external capture RAM write port.
- Reports busy, done and error status to the host register block.

Parameters:
ADDR_W, 10, capture RAM address width; max capture length 2^ADDR_W
DATA_W, 16, per-channel sample width; RAM word is 2*DATA_W
DEC_W, 8, decimation control width

Ports:
sys_clk  in  1  single clock; all inputs are synchronous to it
i_io_reset  in  1  reset, asynchronous, active-high
i_cfg_over  in  1  ADC SPI configuration/calibration complete (level)
i_start  in  1  one-cycle capture request
i_abort  in  1  one-cycle abort request
i_cap_len  in  ADDR_W+1  number of words to write, 1..2^ADDR_W
i_dec  in  DEC_W  keep 1 of every (i_dec+1) valid samples
i_trig_level  in  DATA_W  signed trigger threshold (used only with trigger feature)
i_adi_din  in  DATA_W  I sample, signed
i_adq_din  in  DATA_W  Q sample, signed
i_ad_vl  in  1  sample-pair valid
o_ram_we  out  1  RAM write strobe
o_ram_addr  out  ADDR_W  RAM write address
o_ram_wdata  out  2*DATA_W  {Q,I}
o_busy  out  1  high in any state except IDLE
o_done  out  1  sticky, capture completed
o_err  out  1  sticky, cfg_over lost during a capture
o_wr_cnt  out  ADDR_W+1  words written in current or last capture
o_state  out  3  state encoding (IDLE=0, WAIT_CFG=1, ARM=2, CAPTURE=3, DONE=4)

Behaviour:
- Reset: every output is 0 and the state is IDLE.
- IDLE:
  - An i_start with i_cap_len != 0 latches i_cap_len, i_dec and i_trig_level, clears o_done, o_err and o_wr_cnt, and moves to WAIT_CFG.
  - An i_start with i_cap_len == 0 is ignored.
- WAIT_CFG: moves to ARM on the first cycle that i_cfg_over=1. If i_cfg_over is already high, WAIT_CFG lasts exactly one cycle.
- ARM:
  - Without the trigger feature: lasts one cycle, then moves to CAPTURE.
  - With the trigger feature: see Optional Feature.
- CAPTURE:
  - The decimation counter starts at 0.
  - On each cycle with i_ad_vl=1:
    - If the counter is 0, the sample is written and the counter reloads to the latched dec value.
    - Otherwise the counter decrements.
  - Cycles with i_ad_vl=0 have no effect.
- Write timing:
  - A sample accepted in cycle n produces o_ram_we=1 in cycle n+1, with o_ram_wdata={Q,I} of that sample.
  - o_ram_addr starts at 0 and increments by 1 per write.
  - o_wr_cnt increments alongside each write.
  - o_ram_we is otherwise 0; o_ram_addr and o_ram_wdata hold their values.
- Completion: when the write count reaches the latched length, move to DONE. No further samples are accepted; exactly cap_len writes occur.
- DONE: o_done is set to 1 and the state returns to IDLE on the next cycle. o_done stays high until the next accepted start.
- Abort:
  - In any non-IDLE state, i_abort returns the state to IDLE next cycle with o_done=0.
  - A write already registered for the next cycle is suppressed.
  - Abort takes priority over a simultaneous final sample and over trigger detection.
- cfg_over loss: i_cfg_over=0 while in ARM or CAPTURE sets o_err=1 and returns the state to IDLE; o_done stays 0.
- i_start while busy is ignored. Latched parameters do not change during a capture.
- Wrap-around: when cap_len = 2^ADDR_W, the last write is at address 2^ADDR_W-1. The address never wraps within a capture.

Optional Feature:
- Macro AD_TRIG_EN.
- When defined, ARM waits for a rising crossing on I:
  - The previous valid I sample is < level and the current valid I sample is >= level (signed compare).
  - The crossing sample is the first sample written (decimation phase 0), and the state enters CAPTURE in the same cycle.
  - The first valid sample after entering ARM only loads the "previous" register and cannot trigger.
- When undefined, the comparator and previous-sample register are absent, i_trig_level is unused, and ARM lasts one cycle.

Test Plan:
- cfg_over=1, start, len=4, dec=0, continuous valid, I=0..9 -> 4 writes at addr 0..3 with I=samples after ARM, done=1, wr_cnt=4, busy low.
- len=3, dec=2, continuous valid -> writes of every 3rd sample (samples k, k+3, k+6), each we exactly 1 cycle after its sample.
- cfg_over=0 at start, raised 20 cycles later -> state stays WAIT_CFG for 20 cycles, no writes before cfg_over; then drop cfg_over mid-capture -> err=1, done=0, state IDLE.
- Abort in the same cycle as the final valid sample of len=2 -> only 1 write, done=0, state IDLE; a subsequent start with len=0 is ignored.
- AD_TRIG_EN, level=100, I sequence 50,90,120,130 -> first write carries I=120; I sequence 150,160 (no crossing) -> no writes, stays ARM.
- len=2^ADDR_W=1024, dec=0 -> last write at addr 1023, wr_cnt=1024, done=1; start pulsed during capture is ignored.

Source files
------------

// File: rtl/ad_capture_ctrl.sv
// ad_capture_ctrl: ADS42 I/Q capture sequencer writing decimated {Q,I} pairs to capture RAM.
// Define AD_TRIG_EN to arm on a rising I-channel level crossing instead of a one-cycle ARM.
module ad_capture_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16,
    parameter int DEC_W  = 8
) (
    input  logic                sys_clk,
    input  logic                i_io_reset,
    input  logic                i_cfg_over,
    input  logic                i_start,
    input  logic                i_abort,
    input  logic [ADDR_W:0]     i_cap_len,
    input  logic [DEC_W-1:0]    i_dec,
    input  logic [DATA_W-1:0]   i_trig_level,
    input  logic [DATA_W-1:0]   i_adi_din,
    input  logic [DATA_W-1:0]   i_adq_din,
    input  logic                i_ad_vl,
    output logic                o_ram_we,
    output logic [ADDR_W-1:0]   o_ram_addr,
    output logic [2*DATA_W-1:0] o_ram_wdata,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_err,
    output logic [ADDR_W:0]     o_wr_cnt,
    output logic [2:0]          o_state
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WAIT = 3'd1;
    localparam logic [2:0] S_ARM  = 3'd2;
    localparam logic [2:0] S_CAP  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]          r_state;
    logic [ADDR_W:0]     r_len;
    logic [DEC_W-1:0]    r_dec;
    logic [DEC_W-1:0]    r_dec_cnt;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [2*DATA_W-1:0] r_wdata;
    logic                r_done;
    logic                r_err;
    logic [ADDR_W:0]     r_wr_cnt;
    logic                w_arm_hit;
    logic                w_acc;
    logic                w_last;
    logic [ADDR_W:0]     w_wr_nx;

`ifdef AD_TRIG_EN
    logic signed [DATA_W-1:0] r_lvl;
    logic signed [DATA_W-1:0] r_prev;
    logic                     r_prev_v;
    assign w_arm_hit = r_prev_v && (r_prev < r_lvl) && ($signed(i_adi_din) >= r_lvl);
`else
    logic w_unused;
    assign w_unused  = ^i_trig_level;
    assign w_arm_hit = 1'b0;
`endif

    // abort and cfg_over loss both veto the sample, so no write gets registered
    assign w_acc   = i_ad_vl && i_cfg_over && !i_abort &&
                     ((r_state == S_CAP && r_dec_cnt == '0) || (r_state == S_ARM && w_arm_hit));
    assign w_wr_nx = r_wr_cnt + 1'b1;
    assign w_last  = w_acc && (w_wr_nx == r_len);

    always_ff @(posedge sys_clk or posedge i_io_reset) begin
        if (i_io_reset) begin
            r_state   <= S_IDLE;
            r_len     <= '0;
            r_dec     <= '0;
            r_dec_cnt <= '0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_wr_cnt  <= '0;
`ifdef AD_TRIG_EN
            r_lvl     <= '0;
            r_prev    <= '0;
            r_prev_v  <= 1'b0;
`endif
        end else begin
            r_we <= w_acc;
            if (w_acc) begin
                r_addr    <= r_wr_cnt[ADDR_W-1:0];
                r_wdata   <= {i_adq_din, i_adi_din};
                r_wr_cnt  <= w_wr_nx;
                r_dec_cnt <= r_dec;
            end else if (r_state == S_CAP && i_ad_vl && r_dec_cnt != '0) begin
                r_dec_cnt <= r_dec_cnt - 1'b1;
            end
`ifdef AD_TRIG_EN
            if (r_state == S_ARM && i_ad_vl) begin
                r_prev   <= i_adi_din;
                r_prev_v <= 1'b1;
            end
`endif
            case (r_state)
                S_IDLE: if (i_start && |i_cap_len) begin
                    r_len     <= i_cap_len;
                    r_dec     <= i_dec;
                    r_dec_cnt <= '0;
                    r_done    <= 1'b0;
                    r_err     <= 1'b0;
                    r_wr_cnt  <= '0;
`ifdef AD_TRIG_EN
                    r_lvl     <= i_trig_level;
                    r_prev_v  <= 1'b0;
`endif
                    r_state   <= S_WAIT;
                end
                S_WAIT: r_state <= i_abort ? S_IDLE : i_cfg_over ? S_ARM : S_WAIT;
                S_ARM: begin
                    if (i_abort) begin
                        r_state <= S_IDLE;
                    end else if (!i_cfg_over) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
`ifdef AD_TRIG_EN
                        r_state <= !w_acc ? S_ARM : w_last ? S_DONE : S_CAP;
`else
                        r_state <= S_CAP;
`endif
                    end
                end
                S_CAP: begin
                    if (i_abort) begin
                        r_state <= S_IDLE;
                    end else if (!i_cfg_over) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else if (w_last) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= !i_abort;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_ram_we    = r_we;
    assign o_ram_addr  = r_addr;
    assign o_ram_wdata = r_wdata;
    assign o_busy      = r_state != S_IDLE;
    assign o_done      = r_done;
    assign o_err       = r_err;
    assign o_wr_cnt    = r_wr_cnt;
    assign o_state     = r_state;
endmodule

// File: tb/tb_ad_capture_ctrl.sv
// tb_ad_capture_ctrl: directed bench with a write scoreboard for ad_capture_ctrl.
// Default trigger level tracks the first capturable sample so both builds share one timeline.
module tb_ad_capture_ctrl;
    logic        sys_clk = 1'b0;
    logic        i_io_reset, i_cfg_over, i_start, i_abort, i_ad_vl;
    logic [10:0] i_cap_len;
    logic [7:0]  i_dec;
    logic [15:0] i_trig_level, i_adi_din, i_adq_din;
    logic        o_ram_we, o_busy, o_done, o_err;
    logic [9:0]  o_ram_addr;
    logic [31:0] o_ram_wdata;
    logic [10:0] o_wr_cnt;
    logic [2:0]  o_state;

    typedef struct { int c; logic [9:0] a; logic [31:0] d; } wr_t;
    wr_t sb[$];
    int  errs = 0, checks = 0, cyc = 0;
    int  gk, wr, ph, glen, gdec, lead;

    ad_capture_ctrl dut (
        .sys_clk(sys_clk), .i_io_reset(i_io_reset), .i_cfg_over(i_cfg_over),
        .i_start(i_start), .i_abort(i_abort), .i_cap_len(i_cap_len), .i_dec(i_dec),
        .i_trig_level(i_trig_level), .i_adi_din(i_adi_din), .i_adq_din(i_adq_din),
        .i_ad_vl(i_ad_vl), .o_ram_we(o_ram_we), .o_ram_addr(o_ram_addr),
        .o_ram_wdata(o_ram_wdata), .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
        .o_wr_cnt(o_wr_cnt), .o_state(o_state)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mon;
        wr_t e;
        if (o_ram_we) begin
            if (sb.size() == 0) chk("we_unexpected", o_ram_we, 0);
            else begin
                e = sb.pop_front();
                chk("we_cycle", cyc, e.c);
                chk("we_addr", o_ram_addr, e.a);
                chk("we_data", o_ram_wdata, e.d);
            end
        end
    endtask

    task automatic tick;
        @(negedge sys_clk);
        mon();
        @(posedge sys_clk);
        #1;
        cyc++;
    endtask

    task automatic push(input int a, input logic [31:0] d);
        wr_t e;
        e.c = cyc + 1;
        e.a = 10'(a);
        e.d = d;
        sb.push_back(e);
    endtask

    task automatic start_cap(input int len, input int dec);
        i_start = 1; i_cap_len = 11'(len); i_dec = 8'(dec);
        tick;
        i_start = 0;
        gk = 0; wr = 0; ph = 0; glen = len; gdec = dec;
    endtask

    task automatic feed(input int n);
        for (int j = 0; j < n; j++) begin
            i_ad_vl = 1; i_adi_din = 16'(gk); i_adq_din = ~16'(gk);
            if (gk >= lead && wr < glen) begin
                if (ph == 0) begin
                    push(wr, {~16'(gk), 16'(gk)});
                    wr++;
                    ph = gdec;
                end else ph--;
            end
            tick;
            gk++;
        end
        i_ad_vl = 0;
    endtask

    task automatic drain;
        repeat (4) tick;
        chk("sb_drained", sb.size(), 0);
    endtask

    initial begin
        i_io_reset = 1; i_cfg_over = 1; i_start = 0; i_abort = 0; i_ad_vl = 0;
        i_cap_len = 0; i_dec = 0; i_trig_level = 2; i_adi_din = 0; i_adq_din = 0; lead = 2;
        tick; tick;
        chk("rst_we", o_ram_we, 0);
        chk("rst_addr", o_ram_addr, 0);
        chk("rst_wdata", o_ram_wdata, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_err", o_err, 0);
        chk("rst_wr_cnt", o_wr_cnt, 0);
        chk("rst_state", o_state, 0);
        i_io_reset = 0;
        tick;

        // len=4 dec=0, continuous valid
        start_cap(4, 0);
        chk("t1_wait", o_state, 1);
        feed(1);
        chk("t1_arm", o_state, 2);
        feed(9);
        drain;
        chk("t1_done", o_done, 1);
        chk("t1_wr_cnt", o_wr_cnt, 4);
        chk("t1_busy", o_busy, 0);
        chk("t1_state", o_state, 0);
        chk("t1_err", o_err, 0);

        // len=3 dec=2
        start_cap(3, 2);
        chk("t2_done_clr", o_done, 0);
        feed(12);
        drain;
        chk("t2_done", o_done, 1);
        chk("t2_wr_cnt", o_wr_cnt, 3);

        // cfg_over late, then lost mid-capture
        i_cfg_over = 0; lead = 22; i_trig_level = 22;
        start_cap(5, 0);
        chk("t3_done_clr", o_done, 0);
        repeat (20) begin
            chk("t3_wait_cfg", o_state, 1);
            feed(1);
        end
        i_cfg_over = 1;
        feed(4);
        i_cfg_over = 0; i_ad_vl = 1; i_adi_din = 16'(gk);
        tick;
        i_ad_vl = 0;
        chk("t3_err", o_err, 1);
        chk("t3_done", o_done, 0);
        chk("t3_state", o_state, 0);
        chk("t3_wr_cnt", o_wr_cnt, 2);
        i_cfg_over = 1;
        drain;

        // abort on final sample, then len=0 start
        lead = 2; i_trig_level = 2;
        start_cap(2, 0);
        feed(3);
        i_abort = 1; i_ad_vl = 1; i_adi_din = 16'(gk);
        tick;
        i_abort = 0; i_ad_vl = 0;
        chk("t4_state", o_state, 0);
        chk("t4_done", o_done, 0);
        chk("t4_wr_cnt", o_wr_cnt, 1);
        drain;
        i_start = 1; i_cap_len = 0;
        tick;
        i_start = 0;
        chk("t4_len0_state", o_state, 0);
        chk("t4_len0_busy", o_busy, 0);
        chk("t4_len0_wr_cnt", o_wr_cnt, 1);

`ifdef AD_TRIG_EN
        begin
            int tv[5] = '{0, 50, 90, 120, 130};
            int nv[4] = '{0, 150, 160, 170};
            i_trig_level = 100;
            start_cap(2, 0);
            for (int j = 0; j < 5; j++) begin
                i_ad_vl = 1; i_adi_din = 16'(tv[j]); i_adq_din = 16'(j);
                if (j >= 3) push(j - 3, {16'(j), 16'(tv[j])});
                tick;
            end
            i_ad_vl = 0;
            drain;
            chk("t5_done", o_done, 1);
            chk("t5_wr_cnt", o_wr_cnt, 2);
            start_cap(2, 0);
            for (int j = 0; j < 4; j++) begin
                i_ad_vl = 1; i_adi_din = 16'(nv[j]);
                tick;
            end
            i_ad_vl = 0;
            chk("t5_no_cross_state", o_state, 2);
            chk("t5_no_cross_cnt", o_wr_cnt, 0);
            i_abort = 1;
            tick;
            i_abort = 0;
            chk("t5_abort_state", o_state, 0);
            chk("t5_abort_done", o_done, 0);
            drain;
            i_trig_level = 2;
        end
`endif

        // full-depth capture with start pulsed mid-way
        start_cap(1024, 0);
        feed(500);
        i_start = 1; i_cap_len = 3;
        feed(1);
        i_start = 0; i_cap_len = 1024;
        feed(530);
        drain;
        chk("t6_wr_cnt", o_wr_cnt, 1024);
        chk("t6_done", o_done, 1);
        chk("t6_last_addr", o_ram_addr, 1023);
        chk("t6_state", o_state, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
